// File: rtl/aes_key_expand_if.sv
// Key-in / round-key-out handshake bundle for the AES-128 key schedule.
interface aes_key_expand_if;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         busy;

    modport master (
        output key_valid, key, rk_ready,
        input  key_ready, rk_valid, rk, rk_idx, busy
    );

    modport slave (
        input  key_valid, key, rk_ready,
        output key_ready, rk_valid, rk, rk_idx, busy
    );
endinterface

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: accepts one cipher key, then streams round keys 0..10.
// Also holds the combinational AES S-box used by SubWord.

module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ s;
            s = xtime(s);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform
    always_comb begin
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, a);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, a);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, a);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, a);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, a);
        inv  = gf_mul(x127, x127);
        y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic              clk,
    input  logic              rst_n,
    aes_key_expand_if.slave   bus
);
    localparam int unsigned KEY_W    = 128;
    localparam int unsigned IDX_W    = 4;
    localparam logic [3:0]  LAST_IDX = 4'd10;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   rk_q, rk_d;
    logic [IDX_W-1:0]   rk_idx_q, rk_idx_d;
    logic               rk_valid_q, rk_valid_d;

    logic [31:0]        w0, w1, w2, w3, rot, sub, t;
    logic [31:0]        n0, n1, n2, n3;
    logic [7:0]         rcon;

    assign w0  = rk_q[127:96];
    assign w1  = rk_q[95:64];
    assign w2  = rk_q[63:32];
    assign w3  = rk_q[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
    end

    // rcon for the index being produced next (rk_idx_q + 1)
    always_comb begin
        rcon = 8'h00;
        case (rk_idx_q)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t  = sub ^ {rcon, 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    always_comb begin
        state_d    = state_q;
        rk_d       = rk_q;
        rk_idx_d   = rk_idx_q;
        rk_valid_d = rk_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    state_d    = EMIT;
                    rk_d       = bus.key;
                    rk_idx_d   = '0;
                    rk_valid_d = 1'b1;
                end
            end
            EMIT: begin
                if (bus.rk_ready) begin
                    if (rk_idx_q == LAST_IDX) begin
                        state_d    = IDLE;
                        rk_valid_d = 1'b0;
                    end else begin
                        rk_d     = {n0, n1, n2, n3};
                        rk_idx_d = rk_idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                rk_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rk_q       <= '0;
            rk_idx_q   <= '0;
            rk_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rk_q       <= rk_d;
            rk_idx_q   <= rk_idx_d;
            rk_valid_q <= rk_valid_d;
        end
    end

    // key_ready and busy are pure decodes of the state register
    assign bus.key_ready = (state_q == IDLE);
    assign bus.busy      = (state_q == EMIT);
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk        = rk_q;
    assign bus.rk_idx    = rk_idx_q;
endmodule
